regfile_param_sb: RTL

- Parametrised successor to the 64-bit ARM register file.
- Configurable data width, register count and read-port count.
- Adds same-cycle write-to-read bypass and a per-register scoreboard of pending writes, so a pipelined datapath can detect RAW hazards.
- Sits between decode/issue (reads, busy marking) and writeback (write port) of the pipelined CPU.

---
 rtl/regfile_param_sb.sv | 84 ++++++++
 1 files changed

// File: rtl/regfile_param_sb.sv
// Parametrised register file with a same-cycle write-to-read bypass and a
// per-register scoreboard of pending writes for RAW hazard detection.
module regfile_param_sb #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_READ = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         RegWrite,
  input  logic [ADDR_W-1:0]            WriteRegister,
  input  logic [DATA_W-1:0]            WriteData,
  input  logic [NUM_READ*ADDR_W-1:0]   ReadRegister,
  output logic [NUM_READ*DATA_W-1:0]   ReadData,
  output logic [NUM_READ-1:0]          ReadBusy,
  input  logic                         IssueValid,
  input  logic [ADDR_W-1:0]            IssueRegister,
  output logic [ADDR_W:0]              BusyCount
);

  localparam int unsigned NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = '1;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic [ADDR_W:0]   count_nxt;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == ZADDR);
  endfunction

  // Register array; writes to the hardwired zero register are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < int'(NREG); r++) regs[r] <= '0;
    end else if (RegWrite && !is_zero(WriteRegister)) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  // Issue sets a busy bit and wins over a same-cycle writeback clear.
  always_comb begin
    busy_nxt  = busy;
    count_nxt = '0;
    for (int r = 0; r < int'(NREG); r++) begin
      if (is_zero(ADDR_W'(r)))
        busy_nxt[r] = 1'b0;
      else if (IssueValid && IssueRegister == ADDR_W'(r))
        busy_nxt[r] = 1'b1;
      else if (RegWrite && WriteRegister == ADDR_W'(r))
        busy_nxt[r] = 1'b0;
      count_nxt = count_nxt + (ADDR_W+1)'(busy_nxt[r]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= '0;
      BusyCount <= '0;
    end else begin
      busy      <= busy_nxt;
      BusyCount <= count_nxt;
    end
  end

  // Combinational read ports with writeback bypass.
  always_comb begin
    ReadData = '0;
    ReadBusy = '0;
    for (int i = 0; i < int'(NUM_READ); i++) begin
      logic [ADDR_W-1:0] ra;
      logic              hit;
      ra  = ReadRegister[i*ADDR_W +: ADDR_W];
      hit = RegWrite && (WriteRegister == ra) && !is_zero(ra);
      if (!reset && !is_zero(ra)) begin
        ReadData[i*DATA_W +: DATA_W] = hit ? WriteData : regs[ra];
        ReadBusy[i] = busy[ra] && !hit;
      end
    end
  end

endmodule
